seq_pattern_tx: RTL and testbench

//   Serial pattern transmitter; drives the seq_in line of the Mealy sequence detector.

---
 rtl/seq_pattern_tx_if.sv | 22 ++
 rtl/seq_pattern_tx.sv | 114 +++++++++++
 tb/tb_seq_pattern_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Parallel-word handshake and serial output bundle for seq_pattern_tx.
// master = word source / stream observer, slave = the transmitter.
interface seq_pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              seq_out;
  logic              seq_active;
  logic              frame_done;

  modport master (
    output data_in, data_valid,
    input  data_ready, seq_out, seq_active, frame_done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, seq_out, seq_active, frame_done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: preamble, data word MSB-first, then idle gap, one bit per clock.
// Latency: first preamble bit on seq_out one edge after the handshake; accepts only while idle.
module seq_pattern_tx #(
  parameter int          DATA_W      = 8,
  parameter int          PRE_LEN     = 4,
  parameter logic [7:0]  PRE_PATTERN = 8'b0000_1011,
  parameter int          GAP_LEN     = 2
) (
  input  logic            i_clock,
  input  logic            i_reset,
  seq_pattern_tx_if.slave bus
);
  localparam int MAX_LEN = (PRE_LEN > DATA_W) ?
                           ((PRE_LEN > GAP_LEN) ? PRE_LEN : GAP_LEN) :
                           ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN);
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int SH_W    = PRE_LEN + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

  state_t           r_state;
  logic [SH_W-1:0]  r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_seq_out;
  logic             r_seq_active;
  logic             r_frame_done;

  logic [SH_W-1:0]  w_load;
  logic             w_hs;

  // Preamble and word share one shift register so seq_out is always its MSB.
  assign w_load = {PRE_PATTERN[PRE_LEN-1:0], bus.data_in};
  assign w_hs   = bus.data_valid & r_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_seq_out    <= 1'b0;
      r_seq_active <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_seq_out    <= 1'b0;
          r_seq_active <= 1'b0;
          r_frame_done <= 1'b0;
          r_ready      <= 1'b1;
          if (w_hs) begin
            r_state      <= S_PRE;
            r_shift      <= {w_load[SH_W-2:0], 1'b0};
            r_cnt        <= CNT_W'(1);
            r_ready      <= 1'b0;
            r_seq_out    <= w_load[SH_W-1];
            r_seq_active <= 1'b1;
          end
        end
        S_PRE: begin
          r_seq_out <= r_shift[SH_W-1];
          r_shift   <= {r_shift[SH_W-2:0], 1'b0};
          if (r_cnt == CNT_W'(PRE_LEN)) begin
            r_state      <= S_DATA;
            r_cnt        <= CNT_W'(1);
            r_frame_done <= (DATA_W == 1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_W'(DATA_W)) begin
            r_seq_out    <= 1'b0;
            r_seq_active <= 1'b0;
            r_frame_done <= 1'b0;
            if (GAP_LEN == 0) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_GAP;
              r_cnt   <= CNT_W'(1);
            end
          end else begin
            r_seq_out    <= r_shift[SH_W-1];
            r_shift      <= {r_shift[SH_W-2:0], 1'b0};
            r_cnt        <= r_cnt + CNT_W'(1);
            // Bit 0 of the word is the one emitted after DATA_W-1 earlier data bits.
            r_frame_done <= (r_cnt == CNT_W'(DATA_W - 1));
          end
        end
        S_GAP: begin
          if (r_cnt == CNT_W'(GAP_LEN)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.data_ready = r_ready;
  assign bus.seq_out    = r_seq_out;
  assign bus.seq_active = r_seq_active;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed steps then random traffic, against a frame-queue model.
module tb_seq_pattern_tx;
  localparam int         DATA_W  = 8;
  localparam int         PRE_LEN = 4;
  localparam int         GAP_LEN = 2;
  localparam logic [3:0] PRE     = 4'b1011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.DATA_W(DATA_W)) bus ();

  seq_pattern_tx #(
    .DATA_W(DATA_W), .PRE_LEN(PRE_LEN), .PRE_PATTERN(8'b0000_1011), .GAP_LEN(GAP_LEN)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: each queued entry is {seq_out, seq_active, frame_done} for one future cycle.
  logic [2:0] q[$];
  logic       m_ready = 1'b0;
  logic       e_out, e_act, e_done, e_rdy;

  int         done_cnt = 0;
  logic [2:0] d_hist   = 3'b000;
  int         det_cnt  = 0;
  int         det_cyc  = -1;
  int         acc_cyc  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_frame(input logic [DATA_W-1:0] w);
    for (int i = PRE_LEN - 1; i >= 0; i--) q.push_back({PRE[i], 1'b1, 1'b0});
    for (int i = DATA_W - 1; i >= 0; i--) q.push_back({w[i], 1'b1, (i == 0)});
    for (int i = 0; i < GAP_LEN; i++) q.push_back(3'b000);
  endtask

  task automatic step();
    logic det;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ready = 1'b0;
      {e_out, e_act, e_done} = 3'b000;
    end else if (q.size() > 0) begin
      {e_out, e_act, e_done} = q.pop_front();
      m_ready = 1'b0;
    end else if (m_ready && bus.data_valid) begin
      push_frame(bus.data_in);
      {e_out, e_act, e_done} = q.pop_front();
      m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
      {e_out, e_act, e_done} = 3'b000;
    end
    e_rdy = m_ready;
    #1;
    chk("seq_out",    32'(bus.seq_out),    32'(e_out));
    chk("seq_active", 32'(bus.seq_active), 32'(e_act));
    chk("frame_done", 32'(bus.frame_done), 32'(e_done));
    chk("data_ready", 32'(bus.data_ready), 32'(e_rdy));
    done_cnt += int'(bus.frame_done);
    det = ({d_hist, bus.seq_out} == 4'b1011);
    if (det) begin
      det_cnt++;
      det_cyc = cyc;
    end
    d_hist = {d_hist[1:0], bus.seq_out};
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.data_in    = '0;
    bus.data_valid = 1'b0;

    // Reset for two cycles, then ready one edge after release.
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    step();
    chk("ready_after_release", 32'(bus.data_ready), 32'd1);

    // Single word 8'hA5.
    bus.data_in    = 8'hA5;
    bus.data_valid = 1'b1;
    done_cnt       = 0;
    step();
    bus.data_valid = 1'b0;
    steps(15);
    chk("a5_done_count", 32'(done_cnt), 32'd1);

    // Back-to-back 8'h00 then 8'hFF with valid held high.
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b1;
    step();
    bus.data_in = 8'hFF;
    steps(14);
    chk("b2b_second_accept_ready", 32'(bus.data_ready), 32'd1);
    step();
    chk("b2b_second_pre_bit", 32'(bus.seq_out), 32'd1);
    bus.data_valid = 1'b0;
    steps(16);

    // Word changed while busy must not affect the frame.
    bus.data_in    = 8'h3C;
    bus.data_valid = 1'b1;
    step();
    bus.data_in    = 8'hC3;
    bus.data_valid = 1'b0;
    steps(16);

    // Reset during the third data bit; handshake attempted under reset.
    bus.data_in    = 8'h5A;
    bus.data_valid = 1'b1;
    done_cnt       = 0;
    step();
    bus.data_valid = 1'b0;
    steps(6);
    rst            = 1'b1;
    bus.data_in    = 8'hFF;
    bus.data_valid = 1'b1;
    step();
    chk("abort_active", 32'(bus.seq_active), 32'd0);
    rst = 1'b0;
    step();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    bus.data_in = 8'h96;
    step();
    bus.data_valid = 1'b0;
    steps(16);

    // Loopback detection of 1011 on an all-zero word.
    steps(2);
    d_hist         = 3'b000;
    det_cnt        = 0;
    det_cyc        = -1;
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b1;
    acc_cyc        = cyc;
    step();
    bus.data_valid = 1'b0;
    steps(15);
    chk("det_count", 32'(det_cnt), 32'd1);
    chk("det_cycle", 32'(det_cyc), 32'(acc_cyc + 3));

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(63) == 0);
      bus.data_valid = ($urandom_range(3) != 0);
      bus.data_in    = DATA_W'($urandom);
      step();
    end
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    steps(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
